// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: captures EX result/control and runs the data-memory request/complete handshake.
// Latency: non-memory ops spend one cycle in MEM; memory ops retire in the cycle Mem_done is seen.
// Backpressure: Stall_EX holds EX and upstream while an access is outstanding, and is released combinationally by Mem_done.
module ex_mem_pipe #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Valid_EX,
  input  logic        Flush_EX,
  input  logic        RegWrite_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic        Halt_EX,
  input  logic [2:0]  Write_register_EX,
  input  logic [15:0] ALU_result_EX,
  input  logic [15:0] Write_data_EX,
  input  logic        Mem_done,
  input  logic [15:0] Mem_rdata,
  output logic        Mem_req,
  output logic        Mem_wr,
  output logic [15:0] Mem_addr,
  output logic [15:0] Mem_wdata,
  output logic        Valid_MEM,
  output logic        RegWrite_MEM,
  output logic        MemRead_MEM,
  output logic [2:0]  Write_register_MEM,
  output logic [15:0] ALU_result_MEM,
  output logic [15:0] Load_data_MEM,
  output logic        Done_MEM,
  output logic        Halt_MEM,
  output logic        Stall_EX,
  output logic        Err_MEM
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        halt;
    logic [2:0]  writeReg;
    logic [15:0] aluResult;
    logic [15:0] writeData;
  } stage_t;

  stage_t           exIn;
  stage_t           memQ;
  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W:0]   cntInc;
  logic             memReqQ;
  logic             errQ;
  logic             memOp;
  logic             exMemOp;
  logic             stall;
  logic             latchEn;
  logic             hitLimit;

  // Capture value from EX: an empty or squashed slot enters MEM as a control-free bubble
  always_comb begin
    exIn           = '0;
    exIn.valid     = Valid_EX & ~Flush_EX;
    exIn.regWrite  = RegWrite_EX & exIn.valid;
    exIn.memRead   = MemRead_EX & exIn.valid;
    exIn.memWrite  = MemWrite_EX & exIn.valid;
    exIn.halt      = Halt_EX & exIn.valid;
    exIn.writeReg  = Write_register_EX;
    exIn.aluResult = ALU_result_EX;
    exIn.writeData = Write_data_EX;
  end

  // Stall is combinational on Mem_done so a completing access frees the pipe in the same cycle
  assign memOp    = memQ.valid & (memQ.memRead | memQ.memWrite);
  assign exMemOp  = exIn.memRead | exIn.memWrite;
  assign stall    = memOp & ~Mem_done & ~errQ;
  assign latchEn  = ~stall & ~errQ;
  assign cntInc   = {1'b0, waitCnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hitLimit = cntInc >= (CNT_W + 1)'(TIMEOUT);

  // Pipeline register: loads every unstalled edge, frozen once the error is latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memQ <= '0;
    end else if (latchEn) begin
      memQ <= exIn;
    end
  end

  // Handshake FSM with registered request, wait counter and sticky timeout error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      waitCnt <= '0;
      memReqQ <= 1'b0;
      errQ    <= 1'b0;
    end else if (!errQ) begin
      case (state)
        S_IDLE: begin
          if (latchEn && exMemOp) begin
            state   <= S_WAIT;
            memReqQ <= 1'b1;
            waitCnt <= '0;
          end
        end
        S_WAIT: begin
          if (Mem_done) begin
            // The next instruction latches on this same edge; chain straight into its access
            state   <= exMemOp ? S_WAIT : S_IDLE;
            memReqQ <= exMemOp;
            waitCnt <= '0;
          end else if (hitLimit) begin
            errQ    <= 1'b1;
            memReqQ <= 1'b0;
            waitCnt <= cntInc[CNT_W-1:0];
          end else begin
            waitCnt <= cntInc[CNT_W-1:0];
          end
        end
        default: begin
          state   <= S_IDLE;
          memReqQ <= 1'b0;
        end
      endcase
    end
  end

  assign Mem_req            = memReqQ;
  assign Mem_wr             = memReqQ & memQ.memWrite;
  assign Mem_addr           = memQ.aluResult;
  assign Mem_wdata          = memQ.writeData;
  assign Valid_MEM          = memQ.valid;
  assign RegWrite_MEM       = memQ.valid & memQ.regWrite;
  assign MemRead_MEM        = memQ.valid & memQ.memRead;
  assign Halt_MEM           = memQ.valid & memQ.halt;
  assign Write_register_MEM = memQ.writeReg;
  assign ALU_result_MEM     = memQ.aluResult;
  assign Load_data_MEM      = (MemRead_MEM && Mem_done) ? Mem_rdata : 16'h0000;
  assign Done_MEM           = memQ.valid & ~stall & ~errQ;
  assign Stall_EX           = stall;
  assign Err_MEM            = errQ;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed corner cases, then random instruction stream against a memory responder.
// Retirements and memory requests are predicted at issue and checked by independent monitor processes.
// Random memory latency 0..2 cycles plus spurious idle Mem_done pulses exercise stall and back-to-back paths.
module tb_ex_mem_pipe;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        Valid_EX, Flush_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, Halt_EX;
  logic [2:0]  Write_register_EX;
  logic [15:0] ALU_result_EX, Write_data_EX;
  logic        Mem_done;
  logic [15:0] Mem_rdata;
  logic        Mem_req, Mem_wr, Valid_MEM, RegWrite_MEM, MemRead_MEM;
  logic [15:0] Mem_addr, Mem_wdata, ALU_result_MEM, Load_data_MEM;
  logic [2:0]  Write_register_MEM;
  logic        Done_MEM, Halt_MEM, Stall_EX, Err_MEM;

  logic        rndPhase = 1'b0;
  logic        dDone = 1'b0;
  logic [15:0] dRdata = 16'h0;
  logic        rDone = 1'b0;
  logic [15:0] rRdata = 16'h0;
  assign Mem_done  = rndPhase ? rDone : dDone;
  assign Mem_rdata = rndPhase ? rRdata : dRdata;

  ex_mem_pipe #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Valid_EX(Valid_EX), .Flush_EX(Flush_EX), .RegWrite_EX(RegWrite_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Halt_EX(Halt_EX),
    .Write_register_EX(Write_register_EX), .ALU_result_EX(ALU_result_EX),
    .Write_data_EX(Write_data_EX), .Mem_done(Mem_done), .Mem_rdata(Mem_rdata),
    .Mem_req(Mem_req), .Mem_wr(Mem_wr), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Valid_MEM(Valid_MEM), .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
    .Write_register_MEM(Write_register_MEM), .ALU_result_MEM(ALU_result_MEM),
    .Load_data_MEM(Load_data_MEM), .Done_MEM(Done_MEM), .Halt_MEM(Halt_MEM),
    .Stall_EX(Stall_EX), .Err_MEM(Err_MEM)
  );

  int nTests = 0;
  int nFail  = 0;
  int issued = 0;

  typedef struct {
    logic        regWrite;
    logic        memRead;
    logic        halt;
    logic [2:0]  wreg;
    logic [15:0] alu;
    logic [15:0] ldata;
  } retire_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  retire_t     expQ[$];
  req_t        reqQ[$];
  logic [15:0] modelMem[16];
  logic [15:0] respMem[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setEx(input logic v, input logic fl, input logic rw, input logic mr,
                       input logic mw, input logic h, input logic [2:0] wr,
                       input logic [15:0] alu, input logic [15:0] wd);
    Valid_EX = v; Flush_EX = fl; RegWrite_EX = rw; MemRead_EX = mr; MemWrite_EX = mw;
    Halt_EX = h; Write_register_EX = wr; ALU_result_EX = alu; Write_data_EX = wd;
  endtask

  task automatic randInstr();
    int op;
    op = $urandom_range(0, 2);
    Valid_EX          = ($urandom_range(0, 7) != 0);
    Flush_EX          = ($urandom_range(0, 7) == 0);
    MemRead_EX        = (op == 1);
    MemWrite_EX       = (op == 2);
    RegWrite_EX       = (op != 2) && ($urandom_range(0, 3) != 0);
    Halt_EX           = (op == 0) && ($urandom_range(0, 15) == 0);
    Write_register_EX = 3'($urandom);
    ALU_result_EX     = 16'($urandom);
    Write_data_EX     = 16'($urandom);
  endtask

  // Reference model: an instruction accepted from EX retires in program order; memory is a flat array
  task automatic pushExp();
    retire_t r;
    req_t    q;
    if (Valid_EX && !Flush_EX) begin
      r.regWrite = RegWrite_EX;
      r.memRead  = MemRead_EX;
      r.halt     = Halt_EX;
      r.wreg     = Write_register_EX;
      r.alu      = ALU_result_EX;
      r.ldata    = MemRead_EX ? modelMem[ALU_result_EX[3:0]] : 16'h0;
      if (MemWrite_EX) modelMem[ALU_result_EX[3:0]] = Write_data_EX;
      if (MemRead_EX || MemWrite_EX) begin
        q.wr = MemWrite_EX; q.addr = ALU_result_EX; q.wdata = Write_data_EX;
        reqQ.push_back(q);
      end
      expQ.push_back(r);
      issued++;
    end
  endtask

  // Memory responder: checks each new request, then completes it after a random latency
  bit serving = 1'b0;
  int lat = 0;
  always @(negedge clk) begin : responder
    req_t e;
    if (!rndPhase) begin
      rDone   = 1'b0;
      serving = 1'b0;
    end else begin
      rDone  = 1'b0;
      rRdata = 16'($urandom);
      if (Mem_req && !serving) begin
        if (reqQ.size() == 0) begin
          nTests++; nFail++;
          $display("FAIL mem_req_unexpected: got request addr %0h expected none", Mem_addr);
        end else begin
          e = reqQ.pop_front();
          chk("mem_req", 64'({Mem_wr, Mem_addr, (e.wr ? Mem_wdata : 16'h0)}),
                         64'({e.wr, e.addr, (e.wr ? e.wdata : 16'h0)}));
        end
        serving = 1'b1;
        lat = $urandom_range(0, 2);
      end
      if (serving) begin
        if (lat == 0) begin
          rDone  = 1'b1;
          rRdata = respMem[Mem_addr[3:0]];
          if (Mem_wr) respMem[Mem_addr[3:0]] = Mem_wdata;
          serving = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rDone = 1'b1;
      end
    end
  end

  // Retirement monitor
  always @(negedge clk) begin : monitor
    retire_t e;
    #2;
    if (rndPhase && Done_MEM) begin
      if (expQ.size() == 0) begin
        nTests++; nFail++;
        $display("FAIL retire_unexpected: got retire alu %0h expected none", ALU_result_MEM);
      end else begin
        e = expQ.pop_front();
        chk("retire", 64'({RegWrite_MEM, MemRead_MEM, Halt_MEM, Write_register_MEM, ALU_result_MEM, Load_data_MEM}),
                      64'({e.regWrite, e.memRead, e.halt, e.wreg, e.alu, e.ldata}));
      end
    end
  end

  logic acc;

  initial begin
    rst_n = 1'b0;
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      modelMem[i] = 16'(i * 16'h1111) ^ 16'h5A5A;
      respMem[i]  = 16'(i * 16'h1111) ^ 16'h5A5A;
    end
    #12;
    chk("reset_a", 64'({Mem_req, Mem_wr, Mem_addr, Mem_wdata, Valid_MEM, RegWrite_MEM, MemRead_MEM, Write_register_MEM}), 64'h0);
    chk("reset_b", 64'({ALU_result_MEM, Load_data_MEM, Done_MEM, Halt_MEM, Stall_EX, Err_MEM}), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // Single-cycle ALU op
    setEx(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h0);
    step();
    chk("add_fields", 64'({RegWrite_MEM, Write_register_MEM, ALU_result_MEM}), 64'({1'b1, 3'd3, 16'h1234}));
    chk("add_ctrl", 64'({Done_MEM, Stall_EX, Mem_req}), 64'({1'b1, 1'b0, 1'b0}));

    // Load completing in its 4th wait cycle; EX changes meanwhile must not latch
    setEx(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0040, 16'h0);
    step();
    setEx(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 16'h9999, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("load_wait%0d", c), 64'({Mem_req, Stall_EX, Mem_wr, Mem_addr, Write_register_MEM}),
          64'({1'b1, 1'b1, 1'b0, 16'h0040, 3'd5}));
      step();
    end
    dDone = 1'b1; dRdata = 16'hBEEF; #1;
    chk("load_done", 64'({Stall_EX, Done_MEM, Load_data_MEM}), 64'({1'b0, 1'b1, 16'hBEEF}));
    step();
    dDone = 1'b0;
    chk("load_next", 64'({ALU_result_MEM, Write_register_MEM, Valid_MEM}), 64'({16'h9999, 3'd6, 1'b1}));

    // Store then load, each done in its first wait cycle: no bubble between requests
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0010, 16'hCAFE);
    step();
    setEx(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0020, 16'h0);
    dDone = 1'b1; dRdata = 16'h1111; #1;
    chk("b2b_store", 64'({Mem_req, Mem_wr, Mem_addr, Mem_wdata, Done_MEM}), 64'({1'b1, 1'b1, 16'h0010, 16'hCAFE, 1'b1}));
    step();
    dRdata = 16'h5555; #1;
    chk("b2b_load", 64'({Mem_req, Mem_wr, Mem_addr, Load_data_MEM, Done_MEM}), 64'({1'b1, 1'b0, 16'h0020, 16'h5555, 1'b1}));
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    step();
    dDone = 1'b0; #1;
    chk("b2b_idle", 64'({Mem_req, Valid_MEM, Stall_EX}), 64'h0);

    // Flush squashes the EX instruction, but is ignored while stalled
    setEx(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0707, 16'h0);
    step();
    chk("flush", 64'({Valid_MEM, RegWrite_MEM, Done_MEM}), 64'h0);
    setEx(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0030, 16'h0);
    step();
    setEx(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h4444, 16'h0);
    step();
    chk("flush_stall", 64'({Valid_MEM, RegWrite_MEM, MemRead_MEM, Write_register_MEM, ALU_result_MEM, Stall_EX}),
        64'({1'b1, 1'b1, 1'b1, 3'd2, 16'h0030, 1'b1}));
    dDone = 1'b1; dRdata = 16'h7777; #1;
    chk("flush_stall_done", 64'({Done_MEM, Load_data_MEM}), 64'({1'b1, 16'h7777}));
    step();
    dDone = 1'b0; #1;
    chk("flush_after", 64'({Valid_MEM, Done_MEM}), 64'h0);

    // Timeout: load with no completion errors out after TO wait cycles; error is sticky
    setEx(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0050, 16'h0);
    step();
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    for (int c = 1; c <= TO; c++) begin
      chk($sformatf("to_wait%0d", c), 64'({Err_MEM, Mem_req}), 64'({1'b0, 1'b1}));
      step();
    end
    chk("to_err", 64'({Err_MEM, Mem_req, Stall_EX, Done_MEM}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    setEx(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'hAAAA, 16'h0);
    dDone = 1'b1;
    step();
    step();
    chk("to_sticky", 64'({Err_MEM, ALU_result_MEM, Done_MEM, Mem_req}), 64'({1'b1, 16'h0050, 1'b0, 1'b0}));
    dDone = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("to_rst", 64'({Err_MEM, Valid_MEM}), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // Async reset in the 2nd wait cycle of a store
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0060, 16'h6666);
    step();
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    step();
    chk("st_wait2", 64'({Mem_req, Stall_EX, Valid_MEM, Mem_wr}), 64'({1'b1, 1'b1, 1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 64'({Mem_req, Valid_MEM, Stall_EX}), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rst_idle", 64'({Mem_req, Valid_MEM, Stall_EX, Err_MEM}), 64'h0);

    // Random instruction stream against the memory responder
    rndPhase = 1'b1;
    for (int cyc = 0; cyc < 6000 && issued < 400; cyc++) begin
      @(negedge clk);
      #1;
      acc = !Stall_EX;
      if (acc) pushExp();
      @(posedge clk);
      #1;
      if (acc) randInstr();
      else Flush_EX = ($urandom_range(0, 3) == 0);
    end
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    for (int w = 0; w < 60 && (expQ.size() != 0 || reqQ.size() != 0); w++) @(posedge clk);
    #1;
    chk("drain_retire", 64'(expQ.size()), 64'h0);
    chk("drain_req", 64'(reqQ.size()), 64'h0);
    chk("no_err", 64'(Err_MEM), 64'h0);
    chk("issued", 64'(issued >= 400), 64'h1);
    rndPhase = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
